// File: rtl/aes_spi_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_spi_host
// Purpose  : SPI mode-0 master that loads key, message and direction into the
//            AES accelerator, waits for done and reads back the 128-bit result.
// Revision : 1.0
// ============================================================================
module aes_spi_host #(
  parameter int K       = 128,
  parameter int DIV     = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] key_in,
  input  logic [127:0] msg_in,
  input  logic         decrypt,
  input  logic         done_in,
  input  logic         miso,
  output logic         sclk,
  output logic         mosi,
  output logic         ce,
  output logic [127:0] result,
  output logic         valid,
  output logic         busy,
  output logic         error
);

  localparam int N  = K + 136;
  localparam int BW = $clog2(N + 1);
  localparam int CW = $clog2(DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  generate
    if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_key_len
      $error("aes_spi_host: K must be 128, 192 or 256");
    end
    if (DIV < 2) begin : g_bad_div
      $error("aes_spi_host: DIV must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_READ = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           sclk_q, sclk_d;
  logic           ce_q, ce_d;
  logic [127:0]   result_q, result_d;
  logic           valid_q, valid_d;
  logic           error_q, error_d;
  logic [1:0]     done_sync_q;
  logic           done_s;
  logic           cnt_last;

  // done_in comes from the accelerator's clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_sync_q <= 2'b00;
    else       done_sync_q <= {done_sync_q[0], done_in};
  end

  assign done_s   = done_sync_q[1];
  assign cnt_last = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tmo_q    <= '0;
      sclk_q   <= 1'b0;
      ce_q     <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tmo_q    <= tmo_d;
      sclk_q   <= sclk_d;
      ce_q     <= ce_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tmo_d    = tmo_q;
    sclk_d   = sclk_q;
    ce_d     = ce_q;
    result_d = result_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a start coinciding with a completion pulse is dropped
        if (start && !valid_q && !error_q) begin
          sh_d    = {key_in, msg_in, 7'b0, decrypt};
          ce_d    = 1'b1;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_last) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            sh_d   = {sh_q[N-2:0], 1'b0};
            bit_d  = bit_q + BW'(1);
          end else if (bit_q == BW'(N)) begin
            ce_d    = 1'b0;
            tmo_d   = '0;
            state_d = S_ARM;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      S_ARM: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (!done_s) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (done_s) begin
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          state_d = S_READ;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_READ: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_last) begin
          cnt_d = '0;
          if (sclk_q) begin
            // miso is taken on the last high cycle, just before sclk falls
            sclk_d = 1'b0;
            if (bit_q == BW'(127)) begin
              result_d = {sh_q[126:0], miso};
              valid_d  = 1'b1;
              state_d  = S_IDLE;
            end else begin
              sh_d  = {sh_q[N-2:0], miso};
              bit_d = bit_q + BW'(1);
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign sclk   = sclk_q;
  assign ce     = ce_q;
  assign mosi   = ce_q & sh_q[N-1];
  assign result = result_q;
  assign valid  = valid_q;
  assign error  = error_q;
  assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_host
// Purpose  : Self-checking bench: timeline model of the SPI host plus a slave
//            stand-in that captures the load frame and returns a chosen result.
// Revision : 1.0
// ============================================================================
module tb_aes_spi_host;

  localparam int K       = 128;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 100;
  localparam int N       = K + 136;
  localparam int L       = 2 * DIV * N + DIV;
  localparam int R       = 256 * DIV;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [K-1:0] key_in = '0;
  logic [127:0] msg_in = '0;
  logic         decrypt = 1'b0;
  logic         done_in = 1'b0;
  logic         miso = 1'b0;
  logic         sclk, mosi, ce, valid, busy, error;
  logic [127:0] result;

  aes_spi_host #(.K(K), .DIV(DIV), .TIMEOUT(TIMEOUT)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .key_in  (key_in),
    .msg_in  (msg_in),
    .decrypt (decrypt),
    .done_in (done_in),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .ce      (ce),
    .result  (result),
    .valid   (valid),
    .busy    (busy),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [263:0] act, logic [263:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- expectation context (written by stimulus) --------------
  logic [N-1:0] exp_frame = '0;
  logic [127:0] exp_resp  = '0;
  logic [127:0] s_resp    = '0;
  int           load_t0   = -1;
  int           done_t    = -1;

  // ---------------- slave stand-in ----------------------------------------
  logic [N-1:0] rx = '0;
  int           nedge = 0;
  int           ce_len = 0;
  int           ridx = 0;
  logic         ce_p = 1'b0, sclk_p = 1'b0, done_p = 1'b0;

  always @(negedge clk) begin
    if (ce && !ce_p) begin
      rx = '0; nedge = 0; ce_len = 0;
    end
    if (ce) ce_len++;
    if (ce && sclk && !sclk_p) begin
      rx = {rx[N-2:0], mosi};
      nedge++;
    end
    if (done_in && !done_p) begin
      ridx = 127;
      miso = s_resp[127];
    end else if (!ce && sclk_p && !sclk && ridx > 0) begin
      ridx--;
      miso = s_resp[ridx];
    end
    ce_p = ce; sclk_p = sclk; done_p = done_in;
  end

  // ---------------- timeline model and per-cycle compare --------------------
  int           ph = 0;   // 0 idle, 1 load, 2 arm/wait, 3 read
  int           arm_t0 = 0, rd_t0 = 0, jc = 0;
  logic [127:0] exp_result = '0;
  logic         exp_s, exp_m;

  function automatic logic load_mosi(int j);
    int b = j / (2 * DIV);
    return (b < N) ? exp_frame[N-1-b] : 1'b0;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", {sclk, mosi, ce, valid, busy, error}, 6'b0);
      chk("reset_result", result, 128'h0);
      ph = 0;
      exp_result = '0;
    end else begin
      if (ph == 0 && cyc == load_t0) ph = 1;
      if (ph == 1 && cyc - load_t0 >= L) begin
        ph = 2;
        arm_t0 = cyc;
        chk("frame", rx, exp_frame);
        chk("ce_sclk_rises", nedge, N);
        chk("ce_cycles", ce_len, L);
      end
      if (ph == 2 && sclk) begin
        rd_t0 = cyc - DIV;
        chk("done_latency_2_to_3",
            (done_t >= 0 && rd_t0 - done_t >= 2 && rd_t0 - done_t <= 3), 1'b1);
        ph = 3;
      end
      case (ph)
        1: begin
          jc    = cyc - load_t0;
          exp_s = (jc < 2 * DIV * N) && ((jc / DIV) % 2 == 1);
          exp_m = load_mosi(jc);
          chk("load_outputs", {sclk, mosi, ce, valid, busy, error},
              {exp_s, exp_m, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        2: begin
          if (done_t < 0 && cyc - arm_t0 == TIMEOUT) begin
            chk("error_pulse", {sclk, mosi, ce, valid, busy, error}, 6'b000001);
            chk("error_result_held", result, exp_result);
            ph = 0;
          end else begin
            chk("wait_outputs", {sclk, mosi, ce, valid, busy, error}, 6'b000010);
          end
        end
        3: begin
          jc = cyc - rd_t0;
          if (jc < R) begin
            exp_s = ((jc / DIV) % 2 == 1);
            chk("read_outputs", {sclk, mosi, ce, valid, busy, error},
                {exp_s, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
          end else begin
            chk("valid_pulse", {sclk, mosi, ce, valid, busy, error}, 6'b000100);
            chk("result", result, exp_resp);
            exp_result = exp_resp;
            ph = 0;
          end
        end
        default: begin
          chk("idle_outputs", {sclk, mosi, ce, valid, busy, error}, 6'b0);
          chk("idle_result", result, exp_result);
        end
      endcase
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [K-1:0] k, input logic [127:0] m,
                        input logic d, input logic [127:0] rsp);
    key_in    = k;
    msg_in    = m;
    decrypt   = d;
    exp_frame = {k, m, 7'b0, d};
    exp_resp  = rsp;
    s_resp    = rsp;
    done_t    = -1;
    start     = 1'b1;
    load_t0   = cyc + 1;
    step();
    start     = 1'b0;
  endtask

  task automatic run_op(input logic [K-1:0] k, input logic [127:0] m, input logic d,
                        input logic [127:0] rsp, input int dly, input bit tmo,
                        input bit stale, input bit keep_done, input bit mid_start,
                        input bit pulse_start);
    int w;
    launch(k, m, d, rsp);
    if (mid_start) begin
      repeat (300) step();
      start = 1'b1; key_in = ~k; decrypt = ~d;
      step();
      start = 1'b0;
    end
    w = 0;
    while (ph != 2 && w < L + 20) begin step(); w++; end
    chk("load_exit_reached", ph, 2);
    if (stale) begin
      repeat (30) step();
      done_in = 1'b0;
      repeat (30) step();
      done_in = 1'b1; done_t = cyc;
    end else if (!tmo) begin
      repeat (dly) step();
      done_in = 1'b1; done_t = cyc;
    end
    if (mid_start) begin
      w = 0;
      while (ph != 3 && w < 300) begin step(); w++; end
      repeat (100) step();
      start = 1'b1; key_in = ~k;
      step();
      start = 1'b0;
    end
    if (pulse_start) begin
      w = 0;
      while (!(valid || error) && w < 3000) begin step(); w++; end
      start = 1'b1;
      step();
      start = 1'b0;
    end
    w = 0;
    while (ph != 0 && w < 3000) begin step(); w++; end
    chk("operation_completed", ph, 0);
    if (!keep_done) done_in = 1'b0;
    repeat (5) step();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    int           nv;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();

    // Known-answer encrypt: the slave returns the FIPS-197 ciphertext
    run_op(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
           1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, 0, 0, 0, 0, 0);
    chk("kat_result", result, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("kat_frame", rx, 264'h000102030405060708090a0b0c0d0e0f_00112233445566778899aabbccddeeff_00);
    chk("kat_sclk_rises", nedge, 264);
    chk("kat_ce_cycles", ce_len, 2116);

    // Known-answer decrypt, with ignored starts in LOAD and READ
    run_op(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           1'b1, 128'h00112233445566778899aabbccddeeff, 12, 0, 0, 0, 1, 0);
    chk("dec_result", result, 128'h00112233445566778899aabbccddeeff);
    chk("dec_last_byte", rx[7:0], 8'h01);

    for (int i = 0; i < 5; i++)
      run_op(rnd128(), rnd128(), 1'($urandom_range(0, 1)), rnd128(),
             int'($urandom_range(0, 40)), 0, 0, 0, (i == 1), (i == 2));

    // Timeout: done never rises, start coincides with the error pulse
    held = result;
    run_op(rnd128(), rnd128(), 1'b0, rnd128(), 0, 1, 0, 0, 0, 1);
    chk("timeout_result_unchanged", result, held);

    // Leave done high, then run an operation that starts on the stale level
    run_op(rnd128(), rnd128(), 1'b1, rnd128(), 8, 0, 0, 1, 0, 0);
    run_op(rnd128(), rnd128(), 1'b0, rnd128(), 0, 0, 1, 0, 0, 0);

    // Reset while sclk is high during bit 50 of LOAD
    launch(rnd128(), rnd128(), 1'b0, rnd128());
    while (cyc < load_t0 + 2 * DIV * 50 + DIV + 1) step();
    chk("pre_abort_sclk_high", {sclk, ce, busy}, 3'b111);
    reset = 1'b1;
    #1;
    chk("abort_immediate", {sclk, ce, busy, valid}, 4'b0000);
    repeat (3) step();
    reset = 1'b0;
    done_t = -1;
    repeat (10) step();

    // Restart with a start issued mid-READ; exactly one valid pulse expected
    nv = 0;
    fork
      begin
        repeat (L + R + 200) begin
          @(posedge clk);
          if (valid) nv++;
        end
      end
      run_op(rnd128(), rnd128(), 1'b1, rnd128(), 3, 0, 0, 0, 1, 0);
    join
    chk("single_valid_after_restart", nv, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
